farm_sensor_cond: RTL and testbench

- Conditions the raw farm-road vehicle loop sensor and sends a clean, latched car request to the highway/farm traffic-light FSM.
- Upstream neighbour of the light controller: its car_req output drives the controller's car-present input (C).
- Synchronises and debounces the sensor, holds the request until the controller shows farm green, and counts vehicle arrivals.

---
 rtl/farm_sensor_cond.sv | 95 +++++++++
 tb/tb_farm_sensor_cond.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/farm_sensor_cond.sv
// Farm-road loop sensor conditioner: sync, debounce, latched car request, arrival count.
// Build with FARM_SENSOR_COUNT_EN defined to include the arrival counter; otherwise car_count is zero.
module farm_sensor_cond #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLDOFF_CYCLES  = 2,
    parameter int COUNT_W         = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sensor_raw,
    input  logic               farm_green,
    output logic               car_req,
    output logic               sensor_clean,
    output logic [COUNT_W-1:0] car_count
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int HW = $clog2(HOLDOFF_CYCLES) + 1;
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HO_LAST = HW'(HOLDOFF_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, REQ, SERVED, HOLDOFF} state_t;

    logic          s1, s2;
    logic [DW-1:0] db_cnt;
    state_t        state, next;
    logic [HW-1:0] hold_cnt;

    // Two-flop synchroniser feeding a run-length debounce against the current clean level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1           <= 1'b0;
            s2           <= 1'b0;
            db_cnt       <= '0;
            sensor_clean <= 1'b0;
        end else begin
            s1 <= sensor_raw;
            s2 <= s1;
            if (s2 == sensor_clean) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                sensor_clean <= s2;
                db_cnt       <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            hold_cnt <= '0;
        end else begin
            state    <= next;
            hold_cnt <= (state == HOLDOFF) ? hold_cnt + 1'b1 : '0;
        end
    end

    // Request stays latched in REQ until served, even if the car has already left
    always_comb begin
        next = state;
        case (state)
            IDLE:    if (sensor_clean)          next = REQ;
            REQ:     if (farm_green)            next = SERVED;
            SERVED:  if (!farm_green)           next = HOLDOFF;
            HOLDOFF: if (hold_cnt == HO_LAST)   next = IDLE;
            default:                            next = IDLE;
        endcase
    end

    assign car_req = (state == REQ);

`ifdef FARM_SENSOR_COUNT_EN
    logic               clean_q;
    logic [COUNT_W-1:0] arrivals;

    // Saturating count of debounced rising edges
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clean_q  <= 1'b0;
            arrivals <= '0;
        end else begin
            clean_q <= sensor_clean;
            if (sensor_clean && !clean_q && (arrivals != {COUNT_W{1'b1}}))
                arrivals <= arrivals + 1'b1;
        end
    end

    assign car_count = arrivals;
`else
    assign car_count = '0;
`endif

endmodule

// File: tb/tb_farm_sensor_cond.sv
// Randomized and directed bench for farm_sensor_cond against a sample-history reference model.
module tb_farm_sensor_cond;
    localparam int D  = 4;
    localparam int H  = 2;
    localparam int CW = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          sensor_raw = 1'b0;
    logic          farm_green = 1'b0;
    logic          car_req;
    logic          sensor_clean;
    logic [CW-1:0] car_count;

    int errs = 0;
    int checks = 0;

    farm_sensor_cond #(.DEBOUNCE_CYCLES(D), .HOLDOFF_CYCLES(H), .COUNT_W(CW)) dut (
        .clk(clk), .rst(rst), .sensor_raw(sensor_raw), .farm_green(farm_green),
        .car_req(car_req), .sensor_clean(sensor_clean), .car_count(car_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Reference model: clean flips when the D raw samples taken two edges back all
    // disagree with it; service phase tracked as idle/requesting/served/holdoff-left.
    bit hist[$];
    bit m_clean, m_clean_prev, m_flip, m_old;
    int m_phase;      // 0 idle, 1 requesting, 2 being served, 3 holdoff
    int m_hold_left;
    int m_count;
    int m_sz;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            hist = {};
            for (int i = 0; i < D + 2; i++) hist.push_back(1'b0);
            m_clean = 0; m_clean_prev = 0; m_phase = 0; m_hold_left = 0; m_count = 0;
        end else begin
            m_sz   = hist.size();
            m_old  = m_clean;
            m_flip = 1'b1;
            for (int i = m_sz - 1 - D; i <= m_sz - 2; i++)
                if (hist[i] == m_clean) m_flip = 1'b0;
            if (m_clean && !m_clean_prev && m_count < CMAX) m_count++;
            m_clean_prev = m_clean;
            case (m_phase)
                0: if (m_old) m_phase = 1;
                1: if (farm_green) m_phase = 2;
                2: if (!farm_green) begin m_phase = 3; m_hold_left = H; end
                default: begin
                    m_hold_left--;
                    if (m_hold_left == 0) m_phase = 0;
                end
            endcase
            if (m_flip) m_clean = !m_clean;
            hist.push_back(sensor_raw);
            void'(hist.pop_front());
        end
    end

    function automatic int exp_count(input int n);
`ifdef FARM_SENSOR_COUNT_EN
        return n;
`else
        return 0;
`endif
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            chk("mdl_req", car_req, (m_phase == 1) ? 1 : 0);
            chk("mdl_clean", sensor_clean, m_clean);
            chk("mdl_count", car_count, exp_count(m_count));
        end
    end

    task automatic wait_req(input int limit);
        int n = 0;
        while (!car_req && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (!car_req) chk("req_wait_timeout", car_req, 1);
    endtask

    int sat_exp[5] = '{1, 2, 3, 3, 3};
    int run_left = 0;
    int g_left = 0;

    initial begin
        rst = 1'b0;
        #1 rst = 1'b1;
        #11;
        chk("rst_req", car_req, 0);
        chk("rst_clean", sensor_clean, 0);
        chk("rst_count", car_count, 0);

        // Debounce latency from reset release
        @(negedge clk);
        rst = 1'b0;
        sensor_raw = 1'b1;
        repeat (D + 1) @(posedge clk);
        @(negedge clk);
        chk("lat_clean_e5", sensor_clean, 0);
        @(negedge clk);
        chk("lat_clean_e6", sensor_clean, 1);
        chk("lat_req_e6", car_req, 0);
        @(negedge clk);
        chk("lat_req_e7", car_req, 1);
        chk("lat_count_e7", car_count, exp_count(1));

        // Service handshake with the car already gone
        sensor_raw = 1'b0;
        farm_green = 1'b1;
        @(negedge clk);
        chk("svc_req_drop", car_req, 0);
        repeat (9) @(negedge clk);
        farm_green = 1'b0;
        repeat (H + 3) @(negedge clk);
        chk("svc_no_rereq", car_req, 0);
        chk("svc_clean_low", sensor_clean, 0);

        // Persistent car re-requests after holdoff
        sensor_raw = 1'b1;
        wait_req(20);
        farm_green = 1'b1;
        repeat (5) @(negedge clk);
        farm_green = 1'b0;
        @(negedge clk);
        repeat (H) @(negedge clk);
        chk("persist_req_early", car_req, 0);
        @(negedge clk);
        chk("persist_req_back", car_req, 1);
        chk("persist_count", car_count, exp_count(2));

        // Saturation of the arrival counter
        rst = 1'b1;
        sensor_raw = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sensor_raw = 1'b1;
            repeat (10) @(negedge clk);
            sensor_raw = 1'b0;
            repeat (10) @(negedge clk);
            chk($sformatf("sat_count_%0d", i), car_count, exp_count(sat_exp[i]));
        end

        // Async reset while requesting
        sensor_raw = 1'b1;
        wait_req(20);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_req", car_req, 0);
        chk("arst_clean", sensor_clean, 0);
        chk("arst_count", car_count, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (D + 2) @(posedge clk);
        @(negedge clk);
        chk("arst_req_e6", car_req, 0);
        @(negedge clk);
        chk("arst_req_e7", car_req, 1);

        // Random traffic with an emulated light controller
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (run_left == 0) begin
                sensor_raw = 1'($urandom_range(0, 1));
                run_left = $urandom_range(1, 12);
            end
            run_left--;
            if (g_left > 0) begin
                g_left--;
            end else if (farm_green) begin
                farm_green = 1'b0;
            end else if ((car_req && $urandom_range(0, 3) == 0) || $urandom_range(0, 30) == 0) begin
                farm_green = 1'b1;
                g_left = $urandom_range(0, 8);
            end
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
